// File: rtl/bias_bank_mem.sv
// Multi-bank bias store: words stream into a shadow buffer, which is then copied
// atomically into one active bank; the datapath reads a full bank combinationally.
module bias_bank_mem #(
    parameter int unsigned NUM_FEATURES    = 3,
    parameter int unsigned BIAS_DATA_WIDTH = 32,
    parameter int unsigned NUM_BANKS       = 2,
    localparam int unsigned N      = NUM_FEATURES + 1,
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start,
    input  logic [BANK_W-1:0]                 load_bank,
    input  logic                              load_abort,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic signed [BIAS_DATA_WIDTH-1:0] wr_data,
    input  logic                              commit_hold,
    output logic                              load_done,
    output logic                              load_err,
    input  logic [BANK_W-1:0]                 rd_bank,
    output logic signed [BIAS_DATA_WIDTH-1:0] bias_weights_output [N],
    output logic [NUM_BANKS-1:0]              bank_valid
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BANK_W:0]  NB_LIMIT = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                              state_q;
    state_t                              state_d;
    logic [BANK_W-1:0]                   bank_q;
    logic [CNT_W-1:0]                    wr_ptr;
    logic signed [BIAS_DATA_WIDTH-1:0]   shadow [N];
    logic signed [BIAS_DATA_WIDTH-1:0]   active [NUM_BANKS][N];
    logic                                start_ok;
    logic                                start_bad;
    logic                                accept;
    logic                                do_commit;
    logic                                rd_ok;

    // Next-state and per-edge action decode; abort overrides both final beat and commit
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        accept    = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if ({1'b0, load_bank} < NB_LIMIT) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (wr_valid) begin
                    accept = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (!commit_hold) begin
                    do_commit = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= '0;
            wr_ptr     <= '0;
            wr_ready   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            bank_valid <= '0;
            for (int i = 0; i < int'(N); i++) begin
                shadow[i] <= '0;
            end
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int i = 0; i < int'(N); i++) begin
                    active[b][i] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            wr_ready  <= (state_d == LOAD);
            load_done <= do_commit;
            load_err  <= start_bad;
            if (start_ok) begin
                bank_q <= load_bank;
            end
            if (accept) begin
                shadow[IDX_W'(wr_ptr)] <= wr_data;
                wr_ptr                 <= wr_ptr + CNT_W'(1);
            end else if (state_d != LOAD) begin
                wr_ptr <= '0;
            end
            if (do_commit) begin
                for (int i = 0; i < int'(N); i++) begin
                    active[bank_q][i] <= shadow[i];
                end
                bank_valid[bank_q] <= 1'b1;
            end
        end
    end

    // Read port only ever sees committed banks; out-of-range selects read as zero
    always_comb begin
        rd_ok = ({1'b0, rd_bank} < NB_LIMIT);
        for (int i = 0; i < int'(N); i++) begin
            bias_weights_output[i] = '0;
            if (rd_ok) begin
                bias_weights_output[i] = active[rd_bank][i];
            end
        end
    end

endmodule

// File: tb/tb_bias_bank_mem.sv
// Self-checking bench for bias_bank_mem: directed table loads, random loads against a
// bank-array model, out-of-range bank handling, and async reset mid-load.
module tb_bias_bank_mem;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int NB = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_start = 1'b0;
    logic [0:0]          load_bank = '0;
    logic                load_abort = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic signed [W-1:0] wr_data = '0;
    logic                commit_hold = 1'b0;
    logic                load_done;
    logic                load_err;
    logic [0:0]          rd_bank = '0;
    logic signed [W-1:0] bwo [N];
    logic [NB-1:0]       bank_valid;

    // Three-bank instance so that an out-of-range bank index is representable
    logic                load_start3 = 1'b0;
    logic [1:0]          load_bank3 = '0;
    logic                wr_valid3 = 1'b0;
    logic                wr_ready3;
    logic signed [W-1:0] wr_data3 = '0;
    logic                load_done3;
    logic                load_err3;
    logic [1:0]          rd_bank3 = '0;
    logic signed [W-1:0] bwo3 [N];
    logic [2:0]          bank_valid3;

    bias_bank_mem #(.NUM_FEATURES(3), .BIAS_DATA_WIDTH(W), .NUM_BANKS(NB)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_bank(load_bank),
        .load_abort(load_abort), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .commit_hold(commit_hold), .load_done(load_done),
        .load_err(load_err), .rd_bank(rd_bank), .bias_weights_output(bwo),
        .bank_valid(bank_valid)
    );

    bias_bank_mem #(.NUM_FEATURES(3), .BIAS_DATA_WIDTH(W), .NUM_BANKS(3)) u_dut3 (
        .clk(clk), .rst(rst), .load_start(load_start3), .load_bank(load_bank3),
        .load_abort(1'b0), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_data(wr_data3), .commit_hold(1'b0), .load_done(load_done3),
        .load_err(load_err3), .rd_bank(rd_bank3), .bias_weights_output(bwo3),
        .bank_valid(bank_valid3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]  mdl [NB][N];
    logic [NB-1:0] mdl_valid;

    typedef struct {
        int              bank;
        logic [3:0][31:0] w;
        int              gaps;
        int              hold;
        int              abort_at;
        bit              exp_commit;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(int bank, logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                                logic [31:0] w3, int gaps, int hold, int abort_at, bit exp_commit);
        vec_t v;
        v.bank = bank;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        v.gaps = gaps;
        v.hold = hold;
        v.abort_at = abort_at;
        v.exp_commit = exp_commit;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag);
        for (int b = 0; b < NB; b++) begin
            rd_bank = 1'(b);
            #1;
            for (int i = 0; i < N; i++) begin
                chk({tag, "_out"}, bwo[i], mdl[b][i]);
            end
        end
        chk({tag, "_bank_valid"}, 32'(bank_valid), 32'(mdl_valid));
    endtask

    task automatic clear_model();
        mdl_valid = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < N; i++) begin
                mdl[b][i] = '0;
            end
        end
    endtask

    // One load transaction; returns on the cycle its outcome is visible
    task automatic run_load(int bank, logic [3:0][31:0] w, int gaps, bit rnd_gaps,
                            int hold, int abort_at, bit exp_commit);
        int g;
        commit_hold = 1'b0;
        load_start  = 1'b1;
        load_bank   = 1'(bank);
        step();
        load_start = 1'b0;
        chk("ready_after_start", wr_ready, 1);
        chk("done_not_repeated", load_done, 0);
        chk("no_err_valid_bank", load_err, 0);
        for (int i = 0; i < N; i++) begin
            g = rnd_gaps ? $urandom_range(0, gaps) : gaps;
            for (int k = 0; k < g; k++) begin
                wr_valid   = 1'b0;
                wr_data    = W'($urandom);
                load_start = 1'($urandom_range(0, 1));
                load_bank  = 1'($urandom);
                step();
                load_start = 1'b0;
                chk("ready_in_gap", wr_ready, 1);
                chk("err_start_busy", load_err, 0);
            end
            wr_valid   = 1'b1;
            wr_data    = w[i];
            load_abort = (i == abort_at);
            if (i == N - 1) commit_hold = (hold > 0);
            step();
            wr_valid   = 1'b0;
            load_abort = 1'b0;
            if (i == abort_at) begin
                commit_hold = 1'b0;
                chk("ready_after_abort", wr_ready, 0);
                chk("done_after_abort", load_done, 0);
                check_outputs("abort_load");
                step();
                chk("done_late_abort", load_done, 0);
                chk("ready_idle_abort", wr_ready, 0);
                return;
            end
            chk("ready_during_load", wr_ready, (i < N - 1) ? 1 : 0);
            chk("done_during_load", load_done, 0);
            check_outputs("old_during_load");
        end
        for (int c = 0; c < hold; c++) begin
            step();
            chk("done_while_held", load_done, 0);
            check_outputs("held");
        end
        commit_hold = 1'b0;
        load_abort  = (abort_at == N);
        step();
        load_abort = 1'b0;
        if (exp_commit) begin
            for (int i = 0; i < N; i++) mdl[bank][i] = w[i];
            mdl_valid[bank] = 1'b1;
        end
        chk("done_at_commit", load_done, exp_commit);
        chk("ready_after_commit", wr_ready, 0);
        check_outputs("after_commit");
    endtask

    initial begin
        int nidle;
        int a;
        logic [3:0][31:0] rw;
        logic [31:0] v3 [N];

        clear_model();
        tbl[0] = mk(1, 32'd5, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, -1, 1);
        tbl[1] = mk(0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, -1, 1);
        tbl[2] = mk(0, 32'hA, 32'hB, 32'hC, 32'hD, 2, 4, -1, 1);
        tbl[3] = mk(0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 3, 0);
        tbl[4] = mk(1, 32'h55, 32'h66, 32'h77, 32'h88, 1, 2, 4, 0);
        tbl[5] = mk(1, 32'h99, 32'hAA, 32'hBB, 32'hCC, 0, 0, 0, 0);
        tbl[6] = mk(0, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, -1, 1);
        tbl[7] = mk(1, 32'hCAFE_F00D, 32'h8000_0001, 32'h7, 32'hFFFF_FFFE, 0, 0, -1, 1);

        #2;
        chk("reset_ready", wr_ready, 0);
        chk("reset_done", load_done, 0);
        chk("reset_err", load_err, 0);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed table; consecutive rows start on the previous load_done cycle
        for (int t = 0; t < 8; t++) begin
            run_load(tbl[t].bank, tbl[t].w, tbl[t].gaps, 1'b0, tbl[t].hold,
                     tbl[t].abort_at, tbl[t].exp_commit);
        end
        step();
        chk("done_pulse_one_cycle", load_done, 0);

        // Random loads with random gaps, holds, aborts and idle noise
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) rw[i] = $urandom;
            a = $urandom_range(0, 9);
            if (a > N) a = -1;
            run_load($urandom_range(0, NB - 1), rw, 2, 1'b1, $urandom_range(0, 3), a, a < 0);
            nidle = $urandom_range(0, 2);
            for (int k = 0; k < nidle; k++) begin
                wr_valid   = 1'b1;
                wr_data    = W'($urandom);
                load_abort = 1'($urandom_range(0, 1));
                step();
                wr_valid   = 1'b0;
                load_abort = 1'b0;
                chk("idle_done", load_done, 0);
                chk("idle_ready", wr_ready, 0);
                check_outputs("idle_drop");
            end
        end
        step();

        // Out-of-range bank on a three-bank instance
        load_start3 = 1'b1;
        load_bank3  = 2'd3;
        step();
        load_start3 = 1'b0;
        chk("bad_bank_err", load_err3, 1);
        chk("bad_bank_ready", wr_ready3, 0);
        step();
        chk("bad_bank_err_pulse", load_err3, 0);
        chk("bad_bank_ready_idle", wr_ready3, 0);
        v3[0] = 32'h0BAD_0001; v3[1] = 32'hF000_0002; v3[2] = 32'h3; v3[3] = 32'h8000_0004;
        load_start3 = 1'b1;
        load_bank3  = 2'd2;
        step();
        load_start3 = 1'b0;
        chk("bank2_err", load_err3, 0);
        for (int i = 0; i < N; i++) begin
            wr_valid3 = 1'b1;
            wr_data3  = v3[i];
            step();
        end
        wr_valid3 = 1'b0;
        step();
        chk("bank2_done", load_done3, 1);
        chk("bank2_valid", 32'(bank_valid3), 32'h4);
        rd_bank3 = 2'd2;
        #1;
        for (int i = 0; i < N; i++) chk("bank2_out", bwo3[i], v3[i]);
        rd_bank3 = 2'd3;
        #1;
        for (int i = 0; i < N; i++) chk("oob_rd_zero", bwo3[i], 32'h0);

        // Async reset in the middle of a load clears everything immediately
        load_start = 1'b1;
        load_bank  = 1'b0;
        step();
        load_start = 1'b0;
        wr_valid   = 1'b1;
        wr_data    = 32'h5A5A_5A5A;
        step();
        step();
        wr_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        clear_model();
        chk("rst_mid_ready", wr_ready, 0);
        chk("rst_mid_done", load_done, 0);
        check_outputs("rst_mid");
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_ready", wr_ready, 0);
        check_outputs("post_rst");
        for (int i = 0; i < N; i++) rw[i] = 32'(i * 3 + 1);
        run_load(1, rw, 0, 1'b0, 0, -1, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
